// File: rtl/agg_merger_pkg.sv
// Shared encodings for the agg/byp stream merger.
// Optional packet counters are built when AGG_MERGER_STATS_EN is defined.
package agg_merger_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        XFER_AGG = 2'd1,
        XFER_BYP = 2'd2
    } state_e;

    typedef enum logic {
        AGG = 1'b0,
        BYP = 1'b1
    } grant_e;

endpackage

// File: rtl/axis_reg_slice.sv
// Two-entry register slice: one cycle latency, one beat per cycle,
// asynchronous flush on reset.
module axis_reg_slice #(
    parameter int W = 417
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);

    logic [W-1:0] mem_q [2];
    logic [1:0]   cnt_q, cnt_d;
    logic         wr_q, rd_q;
    logic         push, pop;

    assign in_ready_o  = (cnt_q != 2'd2);
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = mem_q[rd_q];

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    always_comb begin
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 2'd0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (push) wr_q <= ~wr_q;
            if (pop)  rd_q <= ~rd_q;
        end
    end

    // Payload storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= in_data_i;
    end

endmodule

// File: rtl/agg_merger.sv
// Packet-granular round-robin 2:1 AXI4-Stream merger (agg + bypass).
// Define AGG_MERGER_STATS_EN to build the per-input packet counters.
module agg_merger
    import agg_merger_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int STAT_WIDTH           = 32
) (
    input  logic                              axis_aclk,
    input  logic                              axis_reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_agg_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_agg_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_agg_tuser,
    input  logic                              s_axis_agg_tvalid,
    input  logic                              s_axis_agg_tlast,
    output logic                              s_axis_agg_tready,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_byp_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_byp_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_byp_tuser,
    input  logic                              s_axis_byp_tvalid,
    input  logic                              s_axis_byp_tlast,
    output logic                              s_axis_byp_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    input  logic                              stat_clear,
    output logic [STAT_WIDTH-1:0]             pkt_agg_cnt,
    output logic [STAT_WIDTH-1:0]             pkt_byp_cnt
);

    localparam int PW = C_M_AXIS_DATA_WIDTH + C_M_AXIS_DATA_WIDTH / 8
                      + C_M_AXIS_TUSER_WIDTH + 1;

    state_e        state_q;
    grant_e        last_q;
    grant_e        sel;
    logic          sel_valid;
    logic          in_valid, in_last, in_ready, accept;
    logic [PW-1:0] in_pay, out_pay;

    // IDLE arbitrates combinationally so the first beat moves without a bubble.
    always_comb begin
        sel       = AGG;
        sel_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s_axis_agg_tvalid && s_axis_byp_tvalid) begin
                    sel       = (last_q == AGG) ? BYP : AGG;
                    sel_valid = 1'b1;
                end else if (s_axis_agg_tvalid) begin
                    sel       = AGG;
                    sel_valid = 1'b1;
                end else if (s_axis_byp_tvalid) begin
                    sel       = BYP;
                    sel_valid = 1'b1;
                end
            end
            XFER_AGG: begin
                sel       = AGG;
                sel_valid = 1'b1;
            end
            XFER_BYP: begin
                sel       = BYP;
                sel_valid = 1'b1;
            end
            default: begin
                sel       = AGG;
                sel_valid = 1'b0;
            end
        endcase
    end

    assign s_axis_agg_tready = !axis_reset && sel_valid && (sel == AGG) && in_ready;
    assign s_axis_byp_tready = !axis_reset && sel_valid && (sel == BYP) && in_ready;

    assign in_valid = sel_valid &&
                      ((sel == AGG) ? s_axis_agg_tvalid : s_axis_byp_tvalid);
    assign in_last  = (sel == AGG) ? s_axis_agg_tlast : s_axis_byp_tlast;
    assign accept   = in_valid && in_ready && !axis_reset;

    assign in_pay = (sel == AGG)
        ? {s_axis_agg_tlast, s_axis_agg_tuser, s_axis_agg_tkeep, s_axis_agg_tdata}
        : {s_axis_byp_tlast, s_axis_byp_tuser, s_axis_byp_tkeep, s_axis_byp_tdata};

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            state_q <= IDLE;
            last_q  <= BYP;
        end else if (accept) begin
            if (in_last) begin
                state_q <= IDLE;
                last_q  <= sel;
            end else begin
                state_q <= (sel == AGG) ? XFER_AGG : XFER_BYP;
            end
        end
    end

    axis_reg_slice #(
        .W (PW)
    ) u_slice (
        .clk_i       (axis_aclk),
        .rst_i       (axis_reset),
        .in_data_i   (in_pay),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_pay),
        .out_valid_o (m_axis_tvalid),
        .out_ready_i (m_axis_tready)
    );

    assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = out_pay;

`ifdef AGG_MERGER_STATS_EN
    logic [STAT_WIDTH-1:0] agg_cnt_q, agg_cnt_d;
    logic [STAT_WIDTH-1:0] byp_cnt_q, byp_cnt_d;
    logic                  pkt_done;

    assign pkt_done = accept && in_last;

    // Clear wins over a same-cycle increment; counters saturate.
    always_comb begin
        agg_cnt_d = agg_cnt_q;
        byp_cnt_d = byp_cnt_q;
        if (stat_clear) begin
            agg_cnt_d = '0;
            byp_cnt_d = '0;
        end else if (pkt_done) begin
            if (sel == AGG && agg_cnt_q != '1) agg_cnt_d = agg_cnt_q + 1'b1;
            if (sel == BYP && byp_cnt_q != '1) byp_cnt_d = byp_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            agg_cnt_q <= '0;
            byp_cnt_q <= '0;
        end else begin
            agg_cnt_q <= agg_cnt_d;
            byp_cnt_q <= byp_cnt_d;
        end
    end

    assign pkt_agg_cnt = agg_cnt_q;
    assign pkt_byp_cnt = byp_cnt_q;
`else
    logic unused_stat_clear;

    assign unused_stat_clear = stat_clear;
    assign pkt_agg_cnt       = '0;
    assign pkt_byp_cnt       = '0;
`endif

endmodule

// File: tb/tb_agg_merger.sv
// Scoreboard bench for agg_merger: arbitration order, stalls, reset, stats.
module tb_agg_merger;

    typedef struct packed {
        logic         last;
        logic [127:0] user;
        logic [31:0]  keep;
        logic [255:0] data;
    } beat_t;

    logic         clk = 1'b0;
    logic         axis_reset = 1'b1;
    logic [255:0] agg_tdata, byp_tdata, m_tdata;
    logic [31:0]  agg_tkeep, byp_tkeep, m_tkeep;
    logic [127:0] agg_tuser, byp_tuser, m_tuser;
    logic         agg_tvalid, agg_tlast, agg_tready;
    logic         byp_tvalid, byp_tlast, byp_tready;
    logic         m_tvalid, m_tlast, m_tready;
    logic         stat_clear;
    logic [31:0]  pkt_agg_cnt, pkt_byp_cnt;

    int checks = 0;
    int failures = 0;

    beat_t agg_src[$];
    beat_t byp_src[$];
    beat_t exp_q[$];
    bit    agg_en, byp_en;
    bit [3:0] rdy_pat;
    int    cyc;

    bit    agg_hs, byp_hs, out_hs, mvalid_s, mready_s;
    beat_t out_beat;

    always #5 clk = ~clk;

    agg_merger dut (
        .axis_aclk         (clk),
        .axis_reset        (axis_reset),
        .s_axis_agg_tdata  (agg_tdata),
        .s_axis_agg_tkeep  (agg_tkeep),
        .s_axis_agg_tuser  (agg_tuser),
        .s_axis_agg_tvalid (agg_tvalid),
        .s_axis_agg_tlast  (agg_tlast),
        .s_axis_agg_tready (agg_tready),
        .s_axis_byp_tdata  (byp_tdata),
        .s_axis_byp_tkeep  (byp_tkeep),
        .s_axis_byp_tuser  (byp_tuser),
        .s_axis_byp_tvalid (byp_tvalid),
        .s_axis_byp_tlast  (byp_tlast),
        .s_axis_byp_tready (byp_tready),
        .m_axis_tdata      (m_tdata),
        .m_axis_tkeep      (m_tkeep),
        .m_axis_tuser      (m_tuser),
        .m_axis_tvalid     (m_tvalid),
        .m_axis_tlast      (m_tlast),
        .m_axis_tready     (m_tready),
        .stat_clear        (stat_clear),
        .pkt_agg_cnt       (pkt_agg_cnt),
        .pkt_byp_cnt       (pkt_byp_cnt)
    );

    function automatic beat_t mk(input bit last);
        beat_t b;
        b.data = {$urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom};
        b.keep = $urandom;
        b.user = {$urandom, $urandom, $urandom, $urandom};
        b.last = last;
        return b;
    endfunction

    task automatic drive();
        beat_t a, b;
        a = '0;
        b = '0;
        if (agg_src.size() != 0) a = agg_src[0];
        if (byp_src.size() != 0) b = byp_src[0];
        agg_tvalid = agg_en && (agg_src.size() != 0);
        byp_tvalid = byp_en && (byp_src.size() != 0);
        {agg_tlast, agg_tuser, agg_tkeep, agg_tdata} = a;
        {byp_tlast, byp_tuser, byp_tkeep, byp_tdata} = b;
        m_tready = rdy_pat[cyc % 4];
        cyc++;
    endtask

    // One clock: sample handshakes on the falling edge, advance sources after.
    task automatic cycle();
        @(negedge clk);
        agg_hs   = agg_tvalid && agg_tready;
        byp_hs   = byp_tvalid && byp_tready;
        mvalid_s = m_tvalid;
        mready_s = m_tready;
        out_hs   = m_tvalid && m_tready;
        out_beat = {m_tlast, m_tuser, m_tkeep, m_tdata};
        @(posedge clk);
        #1;
        if (agg_hs) void'(agg_src.pop_front());
        if (byp_hs) void'(byp_src.pop_front());
        drive();
    endtask

    task automatic do_reset();
        axis_reset = 1'b1;
        agg_src.delete();
        byp_src.delete();
        exp_q.delete();
        agg_en = 1'b0;
        byp_en = 1'b0;
        rdy_pat = 4'hF;
        stat_clear = 1'b0;
        cyc = 0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        axis_reset = 1'b0;
        drive();
    endtask

    task automatic test_reset();
        rdy_pat = 4'hF;
        cyc = 0;
        stat_clear = 1'b0;
        agg_src.push_back(mk(1'b1));
        agg_en = 1'b1;
        byp_en = 1'b0;
        drive();
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_tvalid got=%b want=0", m_tvalid);
        end
        checks++;
        if ({agg_tready, byp_tready} !== 2'b00) begin
            failures++;
            $display("FAIL reset_tready got=%b want=00", {agg_tready, byp_tready});
        end
        checks++;
        if (pkt_agg_cnt !== 32'd0 || pkt_byp_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_cnt got=%0d/%0d want=0/0", pkt_agg_cnt, pkt_byp_cnt);
        end
    endtask

    task automatic test_single_agg();
        beat_t e;
        int acc_i, out_i, nout;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            e = mk(i == 2);
            agg_src.push_back(e);
            exp_q.push_back(e);
        end
        agg_en = 1'b1;
        drive();
        acc_i = -1;
        out_i = -1;
        nout = 0;
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
            cycle();
            if (agg_hs && acc_i < 0) acc_i = i;
            if (out_hs) begin
                if (out_i < 0) out_i = i;
                nout++;
                e = exp_q.pop_front();
                checks++;
                if (out_beat !== e) begin
                    failures++;
                    $display("FAIL agg3_beat%0d got=%h want=%h", nout, out_beat, e);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL agg3_timeout left=%0d want=0", exp_q.size());
        end
        checks++;
        if (out_i != acc_i + 1) begin
            failures++;
            $display("FAIL agg3_latency got=%0d want=%0d", out_i - acc_i, 1);
        end
        cycle();
        checks++;
`ifdef AGG_MERGER_STATS_EN
        if (pkt_agg_cnt !== 32'd1) begin
            failures++;
            $display("FAIL agg3_cnt got=%0d want=1", pkt_agg_cnt);
        end
`else
        if (pkt_agg_cnt !== 32'd0) begin
            failures++;
            $display("FAIL agg3_cnt got=%0d want=0", pkt_agg_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back();
        beat_t a, b, e;
        int first, last_o, nout;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a = mk(1'b1);
            b = mk(1'b1);
            agg_src.push_back(a);
            byp_src.push_back(b);
            exp_q.push_back(a);
            exp_q.push_back(b);
        end
        agg_en = 1'b1;
        byp_en = 1'b1;
        drive();
        first = -1;
        last_o = -1;
        nout = 0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            cycle();
            if (out_hs) begin
                if (first < 0) first = i;
                last_o = i;
                nout++;
                e = exp_q.pop_front();
                checks++;
                if (out_beat !== e) begin
                    failures++;
                    $display("FAIL b2b_order%0d got=%h want=%h", nout, out_beat.data, e.data);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_timeout left=%0d want=0", exp_q.size());
        end
        checks++;
        if (last_o - first != 7) begin
            failures++;
            $display("FAIL b2b_gapless span=%0d want=7", last_o - first);
        end
        repeat (2) cycle();
        checks++;
        if (m_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain got=%b want=0", m_tvalid);
        end
    endtask

    task automatic test_no_interleave();
        beat_t e;
        int viol;
        bit byp_done;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            e = mk(i == 3);
            byp_src.push_back(e);
            exp_q.push_back(e);
        end
        for (int i = 0; i < 2; i++) begin
            e = mk(i == 1);
            agg_src.push_back(e);
            exp_q.push_back(e);
        end
        byp_en = 1'b1;
        drive();
        viol = 0;
        byp_done = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            cycle();
            if (agg_hs && !byp_done) viol++;
            if (byp_src.size() == 0) byp_done = 1'b1;
            if (byp_src.size() == 3 && !agg_en) begin
                agg_en = 1'b1;
                agg_tvalid = 1'b1;
            end
            if (out_hs) begin
                e = exp_q.pop_front();
                checks++;
                if (out_beat !== e) begin
                    failures++;
                    $display("FAIL nointl_beat got=%h want=%h", out_beat.data, e.data);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL nointl_timeout left=%0d want=0", exp_q.size());
        end
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL nointl_agg_early got=%0d want=0", viol);
        end
    endtask

    task automatic test_stall();
        beat_t e, prev;
        bit prev_stall;
        int nout;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            e = mk(i == 4);
            agg_src.push_back(e);
            exp_q.push_back(e);
        end
        rdy_pat = 4'b1001;
        agg_en = 1'b1;
        drive();
        prev_stall = 1'b0;
        prev = '0;
        nout = 0;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            cycle();
            if (prev_stall) begin
                checks++;
                if (!mvalid_s || out_beat !== prev) begin
                    failures++;
                    $display("FAIL stall_hold got=%h want=%h", out_beat.data, prev.data);
                end
            end
            prev_stall = mvalid_s && !mready_s;
            prev = out_beat;
            if (out_hs) begin
                nout++;
                e = exp_q.pop_front();
                checks++;
                if (out_beat !== e) begin
                    failures++;
                    $display("FAIL stall_beat%0d got=%h want=%h", nout, out_beat.data, e.data);
                end
            end
        end
        rdy_pat = 4'hF;
        repeat (3) begin
            cycle();
            if (out_hs) nout++;
        end
        checks++;
        if (nout != 5 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL stall_count got=%0d want=5", nout);
        end
    endtask

    task automatic test_reset_mid();
        beat_t a, b, e;
        do_reset();
        for (int i = 0; i < 4; i++) agg_src.push_back(mk(i == 3));
        agg_en = 1'b1;
        drive();
        repeat (2) cycle();
        checks++;
        if (m_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got=%b want=1", m_tvalid);
        end
        axis_reset = 1'b1;
        #1;
        checks++;
        if (m_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_tvalid got=%b want=0", m_tvalid);
        end
        agg_src.delete();
        byp_src.delete();
        exp_q.delete();
        drive();
        @(posedge clk);
        #1;
        axis_reset = 1'b0;
        a = mk(1'b1);
        b = mk(1'b1);
        agg_src.push_back(a);
        byp_src.push_back(b);
        exp_q.push_back(a);
        exp_q.push_back(b);
        byp_en = 1'b1;
        drive();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            cycle();
            if (out_hs) begin
                e = exp_q.pop_front();
                checks++;
                if (out_beat !== e) begin
                    failures++;
                    $display("FAIL rstmid_tie got=%h want=%h", out_beat.data, e.data);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rstmid_timeout left=%0d want=0", exp_q.size());
        end
    endtask

`ifdef AGG_MERGER_STATS_EN
    task automatic test_stats();
        do_reset();
        force dut.agg_cnt_q = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        release dut.agg_cnt_q;
        checks++;
        if (pkt_agg_cnt !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL stats_preload got=%h want=fffffffe", pkt_agg_cnt);
        end
        for (int i = 0; i < 3; i++) agg_src.push_back(mk(1'b1));
        agg_en = 1'b1;
        drive();
        for (int i = 0; i < 20 && agg_src.size() != 0; i++) cycle();
        repeat (2) cycle();
        checks++;
        if (pkt_agg_cnt !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL stats_sat got=%h want=ffffffff", pkt_agg_cnt);
        end
        agg_src.push_back(mk(1'b1));
        stat_clear = 1'b1;
        drive();
        cycle();
        stat_clear = 1'b0;
        checks++;
        if (!agg_hs || pkt_agg_cnt !== 32'd0) begin
            failures++;
            $display("FAIL stats_clear hs=%b got=%h want=0", agg_hs, pkt_agg_cnt);
        end
        cycle();
        checks++;
        if (pkt_agg_cnt !== 32'd0) begin
            failures++;
            $display("FAIL stats_clear_hold got=%h want=0", pkt_agg_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_agg();
        test_back_to_back();
        test_no_interleave();
        test_stall();
        test_reset_mid();
`ifdef AGG_MERGER_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
